alu_seq_unit: RTL and testbench

- Parametrised execute unit for the RISC-V datapath: decodes ALUOp/Funct into a 4-bit operation code and computes the result.
- Single-cycle ops (add/sub/and/or/xor) complete in one cycle; shifts and multiply run iteratively over several cycles.
- Sits between the ID/EX register and writeback/branch logic, with a valid/ready handshake on both sides.
- Generalises the plain ALU-control decode with width, extra ops, flags and multi-cycle sequencing.

---
 rtl/alu_seq_unit.sv | 162 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Execute unit: decodes ALUOp/Funct, runs add/sub/logic in one cycle and
// shifts/multiply iteratively, with valid/ready handshakes on both sides.
module alu_seq_unit #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic [3:0]       op_code,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                         OP_SUB = 4'b0110, OP_SRA = 4'b0111, OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]       dec_op, op_q;
  logic [WIDTH-1:0] sc_res, sh_nxt, acc_nxt;
  logic [WIDTH-1:0] work, mplier, acc;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    shamt;
  logic             is_shift, is_mul, go_exec, last;

  always_comb begin
    dec_op = OP_ADD;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (Funct)
          4'b0000: dec_op = OP_ADD;
          4'b1000: dec_op = OP_SUB;
          4'b0111: dec_op = OP_AND;
          4'b0110: dec_op = OP_OR;
          4'b0100: dec_op = OP_XOR;
          4'b0001: dec_op = OP_SLL;
          4'b0101: dec_op = OP_SRL;
          4'b1101: dec_op = OP_SRA;
          default: dec_op = OP_ADD;
        endcase
      end
      default: dec_op = MUL_EN ? OP_MUL : OP_ADD;
    endcase
  end

  assign shamt    = b[SW-1:0];
  assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
  assign is_mul   = (dec_op == OP_MUL);
  assign go_exec  = is_mul || (is_shift && (shamt != '0));

  // Zero-distance shifts fall through the default and return a unchanged.
  always_comb begin
    sc_res = a;
    case (dec_op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      default: sc_res = a;
    endcase
  end

  always_comb begin
    sh_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
    case (op_q)
      OP_SLL:  sh_nxt = work << 1;
      OP_SRL:  sh_nxt = work >> 1;
      default: sh_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? work : '0);
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = go_exec ? EXEC : DONE;
      EXEC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_ADD;
      work   <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      lt     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= dec_op;
          work   <= a;
          mplier <= b;
          acc    <= '0;
          cnt    <= is_mul ? CW'(WIDTH) : (is_shift ? CW'(shamt) : '0);
          if (!go_exec) begin
            result <= sc_res;
            zero   <= (sc_res == '0);
            lt     <= (dec_op == OP_SUB) && ($signed(a) < $signed(b));
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          // Multiply: work is the shifting multiplicand, mplier is consumed LSB first.
          if (op_q == OP_MUL) begin
            work   <= work << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
            if (last) begin
              result <= acc_nxt;
              zero   <= (acc_nxt == '0);
              lt     <= 1'b0;
            end
          end else begin
            work <= sh_nxt;
            if (last) begin
              result <= sh_nxt;
              zero   <= (sh_nxt == '0);
              lt     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign op_code   = op_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomized check of alu_seq_unit (WIDTH=32) against an arithmetic reference
// model, plus directed cases for flags, latency, backpressure and reset.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, zero, lt, busy;
  logic [1:0]   ALUOp;
  logic [3:0]   Funct, op_code;
  logic [W-1:0] a, b, result;

  logic         in_valid0, in_ready0, out_valid0, out_ready0, zero0, lt0, busy0;
  logic [W-1:0] result0;
  logic [3:0]   op_code0;

  int n_vec = 0;
  int n_err = 0;

  alu_seq_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .lt(lt),
    .op_code(op_code), .busy(busy)
  );

  alu_seq_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b), .out_valid(out_valid0),
    .out_ready(out_ready0), .result(result0), .zero(zero0), .lt(lt0),
    .op_code(op_code0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat = cycles after the accept edge until out_valid is first seen (1 = T+1).
  function automatic void model(input logic [1:0] op, input logic [3:0] f, input bit mul_en,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [3:0] oc, output logic [W-1:0] r,
                                output bit l, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    oc  = 4'b0010;
    if (op == 2'b01) oc = 4'b0110;
    else if (op == 2'b11 && mul_en) oc = 4'b1000;
    else if (op == 2'b10) begin
      case (f)
        4'b1000: oc = 4'b0110;
        4'b0111: oc = 4'b0000;
        4'b0110: oc = 4'b0001;
        4'b0100: oc = 4'b0011;
        4'b0001: oc = 4'b0100;
        4'b0101: oc = 4'b0101;
        4'b1101: oc = 4'b0111;
        default: oc = 4'b0010;
      endcase
    end
    lat = 1;
    case (oc)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b0110: r = x - y;
      4'b0100: begin r = x << sh; lat = 1 + sh; end
      4'b0101: begin r = x >> sh; lat = 1 + sh; end
      4'b0111: begin r = W'($signed(x) >>> sh); lat = 1 + sh; end
      4'b1000: begin r = x * y; lat = 1 + W; end
      default: r = x + y;
    endcase
    l = (oc == 4'b0110) && ($signed(x) < $signed(y));
  endfunction

  task automatic scramble();
    in_valid = 1'b1;
    a = $urandom; b = $urandom;
    ALUOp = 2'($urandom); Funct = 4'($urandom);
  endtask

  // hold < 0 picks a random backpressure length.
  task automatic run_op(input logic [1:0] op, input logic [3:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit noise, input int hold);
    logic [3:0]   eoc;
    logic [W-1:0] er;
    bit           el;
    int           lat, cyc, h;
    model(op, f, 1'b1, x, y, eoc, er, el, lat);
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("idle_ready", W'(in_ready), W'(1));
    ALUOp = op; Funct = f; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    if (noise) scramble(); else in_valid = 1'b0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (noise) scramble();
    end
    chk("latency", W'(cyc), W'(lat));
    chk("result", result, er);
    chk("zero", W'(zero), W'(er == '0));
    chk("lt", W'(lt), W'(el));
    chk("op_code", W'(op_code), W'(eoc));
    h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
    repeat (h) begin
      @(negedge clk);
      if (noise) scramble();
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_result", result, er);
      chk("hold_flags", W'({zero, lt}), W'({er == '0, el}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_ready", W'(in_ready), W'(1));
    chk("ret_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]   fl [8];
    logic [1:0]   rop;
    logic [3:0]   rf, eoc;
    logic [W-1:0] er;
    bit           el;
    int           lat;
    fl = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    ALUOp = '0; Funct = '0; a = '0; b = '0;
    #12;
    chk("rst_result", result, '0);
    chk("rst_flags", W'({out_valid, busy, zero, lt}), W'(0));
    chk("rst_op_code", W'(op_code), W'(4'b0010));
    @(negedge clk);
    reset = 1'b1;

    run_op(2'b10, 4'b0000, 32'd5, 32'd7, 1'b0, 0);
    run_op(2'b01, 4'b0101, 32'hFFFF_FFFD, 32'd2, 1'b0, 0);
    run_op(2'b01, 4'b0101, 32'd9, 32'd9, 1'b1, 1);
    run_op(2'b10, 4'b0001, 32'd1, 32'd35, 1'b0, 0);
    run_op(2'b10, 4'b1101, 32'h8000_0000, 32'd4, 1'b1, 2);
    run_op(2'b10, 4'b0101, 32'hABCD_1234, 32'd0, 1'b0, 0);
    run_op(2'b11, 4'b0000, 32'd6, 32'hFFFF_FFFE, 1'b0, 0);
    run_op(2'b10, 4'b1000, 32'd3, 32'd10, 1'b1, 5);
    run_op(2'b10, 4'b0011, 32'd3, 32'd4, 1'b1, 1);

    repeat (150) begin
      rop = 2'($urandom);
      rf  = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 7)] : 4'($urandom);
      run_op(rop, rf, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 7)),
             $urandom_range(0, 1) != 0, -1);
    end

    // Multiply disabled: ALUOp=11 behaves as a single-cycle add.
    repeat (6) begin
      @(negedge clk);
      ALUOp = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      Funct = 4'($urandom); a = $urandom; b = $urandom;
      if (n_vec == 0 || ALUOp == 2'b11) begin a = 32'd6; b = 32'hFFFF_FFFE; end
      model(ALUOp, Funct, 1'b0, a, b, eoc, er, el, lat);
      chk("m0_ready", W'(in_ready0), W'(1));
      in_valid0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid0 = 1'b0;
      chk("m0_valid", W'(out_valid0), W'(lat == 1));
      chk("m0_result", result0, er);
      chk("m0_op_code", W'(op_code0), W'(eoc));
      out_ready0 = 1'b1;
      @(negedge clk);
      out_ready0 = 1'b0;
    end

    // Reset ten cycles into a multiply abandons it.
    @(negedge clk);
    ALUOp = 2'b11; Funct = 4'b0000; a = 32'd123; b = 32'd456; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", W'(busy), W'(1));
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", W'(out_valid), W'(0));
    chk("rst_mid_result", result, '0);
    chk("rst_mid_busy", W'(busy), W'(0));
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b10, 4'b0000, 32'd2, 32'd2, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
